// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: segment codes, conversion FSM states, BCD sizing.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package alu_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // One digit position is always kept free for the minus sign.
   function automatic int bcd_digit_count(input int n_digits);
      return n_digits - 1;
   endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Load/display bundle between the ALU side and the display block.
// Latency and backpressure are defined by the attached module (o_busy gates i_valid).
interface alu_result_display_if #(
   parameter int N        = 5,
   parameter int N_DIGITS = 4
);
   logic [N-1:0]        i_result;
   logic                i_valid;
   logic                o_busy;
   logic [6:0]          o_seg;
   logic [N_DIGITS-1:0] o_an;
   logic                o_dp;

   modport master (
      output i_result, i_valid,
      input  o_busy, o_seg, o_an, o_dp
   );

   modport slave (
      input  i_result, i_valid,
      output o_busy, o_seg, o_an, o_dp
   );
endinterface

// File: rtl/alu_result_display_seg7_decoder.sv
// Digit/minus/blank to active-low segments; purely combinational, zero latency.
// No flow control: output follows inputs; minus outranks blank, blank outranks the digit.
module seg7_decoder
   import alu_display_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   input  logic       i_minus,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (i_minus) begin
         o_seg = SEG_MINUS;
      end else if (!i_blank) begin
         case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_display.sv
// Signed ALU result -> BCD (double-dabble, N+1 cycles after load) -> multiplexed 7-seg display.
// o_busy high during conversion; i_valid is dropped (not queued) while busy. Refresh never stalls.
module alu_result_display
   import alu_display_pkg::*;
#(
   parameter int N           = 5,
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   alu_result_display_if.slave  bus
);

   localparam int ND    = bcd_digit_count(N_DIGITS);
   localparam int BCD_W = 4 * ND;
   localparam int SR_W  = BCD_W + N;
   localparam int CNT_W = $clog2(N + 1);
   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   iter_q, iter_d;
   logic               sign_q, sign_d;
   logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
   logic               disp_neg_q, disp_neg_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [N-1:0]       mag;
   logic [SR_W-1:0]    dab;
   logic [3:0]         cur_digit;
   logic               show_blank, show_minus;
   int                 msd;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         iter_q     <= '0;
         sign_q     <= 1'b0;
         disp_bcd_q <= '0;
         disp_neg_q <= 1'b0;
         ref_q      <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         iter_q     <= iter_d;
         sign_q     <= sign_d;
         disp_bcd_q <= disp_bcd_d;
         disp_neg_q <= disp_neg_d;
         ref_q      <= ref_d;
         idx_q      <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      iter_d     = iter_q;
      sign_d     = sign_q;
      disp_bcd_d = disp_bcd_q;
      disp_neg_d = disp_neg_q;
      // Unsigned magnitude so that the most negative value maps to 2^(N-1).
      mag = bus.i_result[N-1] ? (-bus.i_result) : bus.i_result;
      dab = sr_q;
      for (int k = 0; k < ND; k++) begin
         if (dab[N+4*k +: 4] >= 4'd5) begin
            dab[N+4*k +: 4] = dab[N+4*k +: 4] + 4'd3;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (bus.i_valid) begin
               sign_d  = bus.i_result[N-1];
               sr_d    = {{BCD_W{1'b0}}, mag};
               iter_d  = CNT_W'(N);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d   = {dab[SR_W-2:0], 1'b0};
            iter_d = iter_q - CNT_W'(1);
            if (iter_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            disp_bcd_d = sr_q[SR_W-1 -: BCD_W];
            disp_neg_d = sign_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.o_busy = (state_q != ST_IDLE);
      bus.o_dp   = 1'b1;
   end

   always_comb begin
      ref_d = (ref_q == REF_MAX) ? '0 : ref_q + REF_W'(1);
      idx_d = idx_q;
      if (ref_q == REF_MAX) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // msd: most-significant nonzero digit; the sign sits directly left of it.
   always_comb begin
      msd       = 0;
      cur_digit = 4'd0;
      for (int k = 0; k < ND; k++) begin
         if (disp_bcd_q[4*k +: 4] != 4'd0) msd = k;
         if (int'(idx_q) == k) cur_digit = disp_bcd_q[4*k +: 4];
      end
      show_blank = int'(idx_q) > msd;
      show_minus = disp_neg_q && (disp_bcd_q != '0) && (int'(idx_q) == msd + 1);
      bus.o_an   = '1;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (int'(idx_q) == k) bus.o_an[k] = 1'b0;
      end
   end

   seg7_decoder u_seg7_decoder (
      .i_digit (cur_digit),
      .i_blank (show_blank),
      .i_minus (show_minus),
      .o_seg   (bus.o_seg)
   );

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: constant vector table, hand sequences and a decimal-string reference model.
module tb_alu_result_display;

   localparam int N  = 5;
   localparam int ND = 4;
   localparam int RD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_result_display_if #(.N(N), .N_DIGITS(ND)) bus();

   alu_result_display #(.N(N), .N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model state: shown value, pending value, busy cycles left, edges since reset.
   int m_disp = 0, m_pend = 0, m_busy = 0, m_ref = 0;
   bit m_ok = 1'b0;

   logic [6:0] dig_seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   typedef struct {
      logic [4:0]       res;
      logic [3:0][6:0]  seg;
   } vec_t;

   vec_t tbl [5];

   function automatic int cur_idx();
      return (m_ref / RD) % ND;
   endfunction

   // Expected segments: print the value in decimal, right-align, pick the k-th character from the right.
   function automatic logic [6:0] exp_seg_of(input int val, input int k);
      string s;
      byte   c;
      s = $sformatf("%0d", val);
      if (k >= s.len()) return 7'b1111111;
      c = s[s.len() - 1 - k];
      if (c == "-") return 7'b0111111;
      return dig_seg[c - 8'd48];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic r, v;
      int   val;
      logic [3:0] e_an;
      r   = rst_n;
      v   = bus.i_valid;
      val = $signed(bus.i_result);
      @(posedge clk);
      if (!r) begin
         m_disp = 0; m_busy = 0; m_ref = 0; m_ok = 1'b1;
      end else begin
         m_ref++;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_disp = m_pend;
         end else if (v) begin
            m_pend = val;
            m_busy = N + 1;
         end
      end
      #1;
      if (m_ok) begin
         e_an = 4'b1111;
         e_an[cur_idx()] = 1'b0;
         chk("model_busy", 32'(bus.o_busy), 32'(m_busy > 0));
         chk("model_an",   32'(bus.o_an),   32'(e_an));
         chk("model_seg",  32'(bus.o_seg),  32'(exp_seg_of(m_disp, cur_idx())));
         chk("model_dp",   32'(bus.o_dp),   32'(1'b1));
      end
   endtask

   task automatic load(input logic [4:0] v);
      bus.i_result = v;
      bus.i_valid  = 1'b1;
      tick();
      bus.i_valid  = 1'b0;
   endtask

   task automatic wait_idx(input int k);
      int n;
      n = 0;
      while (cur_idx() != k && n < 20) begin
         tick();
         n++;
      end
      chk("wait_idx_bound", 32'(n < 20), 32'd1);
   endtask

   initial begin
      int busy_cycles;
      tbl[0] = '{5'b01111, {7'b1111111, 7'b1111111, 7'b1111001, 7'b0010010}};
      tbl[1] = '{5'b10000, {7'b1111111, 7'b0111111, 7'b1111001, 7'b0000010}};
      tbl[2] = '{5'b11101, {7'b1111111, 7'b1111111, 7'b0111111, 7'b0110000}};
      tbl[3] = '{5'b11111, {7'b1111111, 7'b1111111, 7'b0111111, 7'b1111001}};
      tbl[4] = '{5'b00000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};

      bus.i_result = '0;
      bus.i_valid  = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_an",   32'(bus.o_an),   32'b1110);
      chk("rst_seg",  32'(bus.o_seg),  32'b1000000);
      chk("rst_dp",   32'(bus.o_dp),   32'd1);
      rst_n = 1'b1;
      repeat (4) tick();
      chk("rst_an_after4",  32'(bus.o_an),  32'b1101);
      chk("rst_seg_after4", 32'(bus.o_seg), 32'b1111111);

      // Vector table: load, let the conversion finish, then scan all digits.
      for (int i = 0; i < 5; i++) begin
         load(tbl[i].res);
         repeat (N + 1) tick();
         chk("tbl_idle", 32'(bus.o_busy), 32'd0);
         for (int c = 0; c < RD * ND; c++) begin
            tick();
            chk($sformatf("tbl%0d_seg_an%0d", i, cur_idx()), 32'(bus.o_seg), 32'(tbl[i].seg[cur_idx()]));
         end
      end

      // Load +7, then a -1 strobe while busy must be dropped.
      load(5'b00111);
      busy_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         if (!bus.o_busy) break;
         busy_cycles++;
         bus.i_result = 5'b11111;
         bus.i_valid  = (c == 1);
         tick();
      end
      bus.i_valid = 1'b0;
      chk("busy_len", 32'(busy_cycles), 32'd6);
      repeat (2) tick();
      chk("drop_still_idle", 32'(bus.o_busy), 32'd0);
      wait_idx(0);
      chk("drop_an0_seg", 32'(bus.o_seg), 32'b1111000);
      wait_idx(1);
      chk("drop_an1_seg", 32'(bus.o_seg), 32'b1111111);

      // Load -9 and reset on the third SHIFT cycle.
      load(5'b10111);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", 32'(bus.o_busy), 32'd0);
      chk("abort_an",   32'(bus.o_an),   32'b1110);
      chk("abort_seg",  32'(bus.o_seg),  32'b1000000);
      load(5'b01100);
      repeat (N + 1) tick();
      wait_idx(0);
      chk("after_abort_an0", 32'(bus.o_seg), 32'b0100100);
      wait_idx(1);
      chk("after_abort_an1", 32'(bus.o_seg), 32'b1111001);

      // Random loads, strobes during busy and occasional resets against the model.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         load(5'($urandom));
         repeat ($urandom_range(0, 12)) begin
            bus.i_valid  = ($urandom_range(0, 3) == 0);
            bus.i_result = 5'($urandom);
            tick();
         end
         bus.i_valid = 1'b0;
      end
      repeat (N + 2 + RD * ND) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
